dispatch_queue: RTL and testbench



---
 rtl/dispatch_queue.sv | 144 ++++++++++++++
 tb/tb_dispatch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// dispatch_queue
//   Small in-order FIFO placed directly upstream of the parameterised
//   demultiplexer. A single producer pushes tagged requests (payload plus
//   destination index). The head entry drives the demultiplexer's data input
//   and select. The head stays in place until the consumer it names
//   acknowledges it, so later entries wait even if they go to another
//   destination.
//
// Ports
//   clock          : single clock, all state updates on the rising edge
//   reset          : synchronous, active-low reset
//   inData         : request payload
//   inDestination  : request destination index
//   inValid        : producer has a request
//   inReady        : queue can accept a request (depends on occupancy only)
//   outData        : head payload, or 0 when empty
//   select         : head destination, or 0 when empty
//   outValid       : head entry is valid
//   outAck         : per-destination acknowledge, one bit per consumer
//   occupancy      : number of stored entries
//   droppedRequest : (only with DISPATCH_QUEUE_RANGE_CHECK_EN) pulses for one
//                    cycle after an out-of-range request is accepted and
//                    discarded
//
// Optional feature macro: DISPATCH_QUEUE_RANGE_CHECK_EN

module dispatch_queue #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUMBER_OF_OUTPUTS = 4,
  parameter int SELECT_WIDTH      = $clog2(NUMBER_OF_OUTPUTS),
  parameter int DEPTH             = 4,
  parameter int COUNT_WIDTH       = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        inData,
  input  logic [SELECT_WIDTH-1:0]      inDestination,
  input  logic                         inValid,
  output logic                         inReady,
  output logic [DATA_WIDTH-1:0]        outData,
  output logic [SELECT_WIDTH-1:0]      select,
  output logic                         outValid,
  input  logic [NUMBER_OF_OUTPUTS-1:0] outAck,
  output logic [COUNT_WIDTH-1:0]       occupancy
`ifdef DISPATCH_QUEUE_RANGE_CHECK_EN
  ,
  output logic                         droppedRequest
`endif
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [PTR_WIDTH-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0]        data_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]        data_mem_d [DEPTH];
  logic [SELECT_WIDTH-1:0]      dest_mem_q [DEPTH];
  logic [SELECT_WIDTH-1:0]      dest_mem_d [DEPTH];

  logic                         accept;
  logic                         store;
  logic                         pop;
  logic [NUMBER_OF_OUTPUTS-1:0] ack_shifted;

  assign inReady   = (count_q < COUNT_WIDTH'(DEPTH));
  assign outValid  = (count_q != '0);
  assign outData   = outValid ? data_mem_q[rd_ptr_q] : '0;
  assign select    = outValid ? dest_mem_q[rd_ptr_q] : '0;
  assign occupancy = count_q;

  // Only the ack bit of the consumer the head is addressed to counts. A shift
  // is used instead of a direct index so a select value beyond the ack
  // vector can never index out of range.
  assign ack_shifted = outAck >> select;
  assign pop         = outValid && ack_shifted[0];

  assign accept = inValid && inReady;

`ifdef DISPATCH_QUEUE_RANGE_CHECK_EN
  logic in_range;
  logic dropped_q, dropped_d;

  // An out-of-range request still completes its handshake. The producer never
  // stalls on it, but it is never written into the queue.
  assign in_range       = ({1'b0, inDestination} < (SELECT_WIDTH + 1)'(NUMBER_OF_OUTPUTS));
  assign store          = accept && in_range;
  assign dropped_d      = accept && !in_range;
  assign droppedRequest = dropped_q;
`else
  assign store = accept;
`endif

  always_comb begin
    data_mem_d = data_mem_q;
    dest_mem_d = dest_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (store) begin
      data_mem_d[wr_ptr_q] = inData;
      dest_mem_d[wr_ptr_q] = inDestination;
      wr_ptr_d             = wr_ptr_q + PTR_WIDTH'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end

    // A push and a pop on the same edge cancel out in the count. Full and
    // empty are told apart by this count alone, never by comparing pointers.
    unique case ({store, pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
`ifdef DISPATCH_QUEUE_RANGE_CHECK_EN
      dropped_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
`ifdef DISPATCH_QUEUE_RANGE_CHECK_EN
      dropped_q <= dropped_d;
`endif
    end
  end

  // Storage is not reset. A slot is only ever read after it has been written.
  always_ff @(posedge clock) begin
    data_mem_q <= data_mem_d;
    dest_mem_q <= dest_mem_d;
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue
//   Directed bench for dispatch_queue (DEPTH=4, NUMBER_OF_OUTPUTS=4,
//   DATA_WIDTH=8). A queue model holds the expected stored entries. Each
//   accepted push is appended to the model, and each acknowledged head is
//   removed from it. The head, occupancy and handshake outputs are compared
//   with the model every cycle. Constants from the test plan are also checked
//   at the key points.

module tb_dispatch_queue;

  localparam int DW = 8;
  localparam int NO = 4;
  localparam int SW = 2;
  localparam int DP = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] dest;
  } entry_t;

  logic          clock;
  logic          reset;
  logic [DW-1:0] inData;
  logic [SW-1:0] inDestination;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] outData;
  logic [SW-1:0] select;
  logic          outValid;
  logic [NO-1:0] outAck;
  logic [CW-1:0] occupancy;
`ifdef DISPATCH_QUEUE_RANGE_CHECK_EN
  logic          droppedRequest;
`endif

  entry_t sb[$];
  int     assertCount = 0;
  int     failCount   = 0;

  dispatch_queue #(
    .DATA_WIDTH       (DW),
    .NUMBER_OF_OUTPUTS(NO),
    .SELECT_WIDTH     (SW),
    .DEPTH            (DP),
    .COUNT_WIDTH      (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .inData       (inData),
    .inDestination(inDestination),
    .inValid      (inValid),
    .inReady      (inReady),
    .outData      (outData),
    .select       (select),
    .outValid     (outValid),
    .outAck       (outAck),
    .occupancy    (occupancy)
`ifdef DISPATCH_QUEUE_RANGE_CHECK_EN
    ,
    .droppedRequest(droppedRequest)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge. It first checks the outputs against the
  // model state, then drives one cycle of inputs. Next it applies the same
  // push/pop decision to the model. Finally it advances to the next falling
  // edge.
  task automatic applyStimulus(input logic rstN, input logic valid,
                               input logic [DW-1:0] data, input logic [SW-1:0] dest,
                               input logic [NO-1:0] ack);
    bit doPush;
    bit doPop;
    int size;
    size = sb.size();

    checkOutput("occupancy", 32'(occupancy), 32'(size));
    checkOutput("inReady", 32'(inReady), 32'(size < DP));
    checkOutput("outValid", 32'(outValid), 32'(size != 0));
    if (size != 0) begin
      checkOutput("head_data", 32'(outData), 32'(sb[0].data));
      checkOutput("head_select", 32'(select), 32'(sb[0].dest));
    end else begin
      checkOutput("empty_data", 32'(outData), 32'(0));
      checkOutput("empty_select", 32'(select), 32'(0));
    end
`ifdef DISPATCH_QUEUE_RANGE_CHECK_EN
    checkOutput("droppedRequest", 32'(droppedRequest), 32'(0));
`endif

    reset         = rstN;
    inValid       = valid;
    inData        = data;
    inDestination = dest;
    outAck        = ack;

    if (!rstN) begin
      sb.delete();
    end else begin
      doPop  = (size != 0) && ack[sb[0].dest];
      doPush = valid && (size < DP);
      if (doPop) void'(sb.pop_front());
      if (doPush) sb.push_back('{data: data, dest: dest});
    end

    @(posedge clock);
    @(negedge clock);
  endtask

  logic [DW-1:0] drainExpect [4];

  initial begin
    reset         = 1'b0;
    inValid       = 1'b0;
    inData        = '0;
    inDestination = '0;
    outAck        = '0;
    @(posedge clock);
    @(negedge clock);
    $display("[TB] reset and idle");

    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
    checkOutput("reset_inReady", 32'(inReady), 32'(1));
    checkOutput("reset_occupancy", 32'(occupancy), 32'(0));

    $display("[TB] single push and selective ack");
    applyStimulus(1'b1, 1'b1, 8'hA5, 2'd2, 4'b0000);
    checkOutput("a5_data", 32'(outData), 32'h0000_00A5);
    checkOutput("a5_select", 32'(select), 32'(2));
    checkOutput("a5_occupancy", 32'(occupancy), 32'(1));
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b0001);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b0001);
    checkOutput("a5_held", 32'(outValid), 32'(1));
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b0100);
    checkOutput("a5_popped", 32'(outValid), 32'(0));

    $display("[TB] fill, refused push, ordered drain");
    applyStimulus(1'b1, 1'b1, 8'h11, 2'd0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h22, 2'd1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h33, 2'd2, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h44, 2'd3, 4'b0000);
    checkOutput("full_occupancy", 32'(occupancy), 32'(4));
    checkOutput("full_inReady", 32'(inReady), 32'(0));
    applyStimulus(1'b1, 1'b1, 8'h55, 2'd1, 4'b0000);
    checkOutput("refused_occupancy", 32'(occupancy), 32'(4));
    drainExpect = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_data", 32'(outData), 32'(drainExpect[i]));
      applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'(1 << i));
    end
    checkOutput("drained_empty", 32'(outValid), 32'(0));

    $display("[TB] simultaneous push/pop with pointer wrap");
    applyStimulus(1'b1, 1'b1, 8'h70, 2'd1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h71, 2'd3, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h66, 2'd0, 4'b0010);
    checkOutput("pp_occupancy", 32'(occupancy), 32'(2));
    checkOutput("pp_head", 32'(outData), 32'h0000_0071);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h80 + i), 2'(i % 4), 4'b1111);
      checkOutput("wrap_occupancy", 32'(occupancy), 32'(2));
    end
    checkOutput("wrap_head", 32'(outData), 32'h0000_0088);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b1111);
    checkOutput("wrap_last", 32'(outData), 32'h0000_0089);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b1111);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b1, 8'h90, 2'd0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h91, 2'd1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h92, 2'd2, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h93, 2'd3, 4'b0000);
    checkOutput("prereset_occupancy", 32'(occupancy), 32'(4));
    applyStimulus(1'b0, 1'b1, 8'hAA, 2'd1, 4'b1111);
    checkOutput("postreset_occupancy", 32'(occupancy), 32'(0));
    checkOutput("postreset_outValid", 32'(outValid), 32'(0));
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'hB1, 2'd3, 4'b0000);
    checkOutput("postreset_push", 32'(outData), 32'h0000_00B1);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b1000);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
